fwd_hazard_ctrl: RTL

- Generalised operand-forwarding and hazard controller for the decode stage of the N-issue pipeline.
- Sits between Decode/RF and IDEX. It selects each slot's rs1/rs2 value from RF, from any in-flight pipeline stage, or from the long-latency writeback port.
- Adds three behaviours: a register scoreboard for multi-cycle ops (div/long load), intra-bundle dependency splitting, and a saturating stall counter.

---
 rtl/fwd_hazard_ctrl_pkg.sv | 9 +
 rtl/fwd_hazard_ctrl_if.sv | 37 +++
 rtl/fwd_hazard_ctrl_src_sel.sv | 46 ++++
 rtl/fwd_hazard_ctrl.sv | 77 +++++++
 4 files changed

// File: rtl/fwd_hazard_ctrl_pkg.sv
// fwd_hazard_ctrl_pkg: stage indices and slot/stage flattening helper
package fwd_hazard_ctrl_pkg;
  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;
  function automatic int flat_idx(input int stg, input int slot, input int n_slot);
    return stg * n_slot + slot;
  endfunction
endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// fwd_hazard_ctrl_if: decode-side bundle, pipeline stage taps and controller results
interface fwd_hazard_ctrl_if #(
  parameter int ISSUE_W       = 2,
  parameter int NUM_STG       = 3,
  parameter int DATA_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH     = 32
);
  logic [ISSUE_W-1:0]                       dec_valid;
  logic [ISSUE_W*RF_ADDR_WIDTH-1:0]         dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
  logic [ISSUE_W-1:0]                       dec_rs1_use, dec_rs2_use, dec_rd_wen, dec_long;
  logic [ISSUE_W*DATA_WIDTH-1:0]            rf_rs1_data, rf_rs2_data;
  logic [NUM_STG*ISSUE_W*RF_ADDR_WIDTH-1:0] stg_rd_addr;
  logic [NUM_STG*ISSUE_W-1:0]               stg_wen, stg_data_vld;
  logic [NUM_STG*ISSUE_W*DATA_WIDTH-1:0]    stg_data;
  logic                                     lwb_valid;
  logic [RF_ADDR_WIDTH-1:0]                 lwb_addr;
  logic [DATA_WIDTH-1:0]                    lwb_data;
  logic                                     issue_fire;
  logic [ISSUE_W*DATA_WIDTH-1:0]            fwd_rs1_data, fwd_rs2_data;
  logic [ISSUE_W-1:0]                       issue_mask;
  logic                                     stall_req;
  logic [CNT_WIDTH-1:0]                     stall_cnt;
  logic [2**RF_ADDR_WIDTH-1:0]              sb_busy;
  modport master (
    output dec_valid, dec_rs1_addr, dec_rs2_addr, dec_rd_addr, dec_rs1_use, dec_rs2_use,
           dec_rd_wen, dec_long, rf_rs1_data, rf_rs2_data, stg_rd_addr, stg_wen,
           stg_data_vld, stg_data, lwb_valid, lwb_addr, lwb_data, issue_fire,
    input  fwd_rs1_data, fwd_rs2_data, issue_mask, stall_req, stall_cnt, sb_busy
  );
  modport slave (
    input  dec_valid, dec_rs1_addr, dec_rs2_addr, dec_rd_addr, dec_rs1_use, dec_rs2_use,
           dec_rd_wen, dec_long, rf_rs1_data, rf_rs2_data, stg_rd_addr, stg_wen,
           stg_data_vld, stg_data, lwb_valid, lwb_addr, lwb_data, issue_fire,
    output fwd_rs1_data, fwd_rs2_data, issue_mask, stall_req, stall_cnt, sb_busy
  );
endinterface

// File: rtl/fwd_hazard_ctrl_src_sel.sv
// fwd_src_sel: priority operand selector over stage taps, long writeback and RF
module fwd_src_sel
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int ISSUE_W       = 2,
  parameter int NUM_STG       = 3,
  parameter int DATA_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH = 5
) (
  input  logic [RF_ADDR_WIDTH-1:0]                 i_addr,
  input  logic                                     i_use,
  input  logic [DATA_WIDTH-1:0]                    i_rf_data,
  input  logic [NUM_STG*ISSUE_W*RF_ADDR_WIDTH-1:0] i_stg_rd_addr,
  input  logic [NUM_STG*ISSUE_W-1:0]               i_stg_wen,
  input  logic [NUM_STG*ISSUE_W-1:0]               i_stg_data_vld,
  input  logic [NUM_STG*ISSUE_W*DATA_WIDTH-1:0]    i_stg_data,
  input  logic                                     i_lwb_valid,
  input  logic [RF_ADDR_WIDTH-1:0]                 i_lwb_addr,
  input  logic [DATA_WIDTH-1:0]                    i_lwb_data,
  input  logic [2**RF_ADDR_WIDTH-1:0]              i_sb_busy,
  output logic [DATA_WIDTH-1:0]                    o_data,
  output logic                                     o_nrdy,
  output logic                                     o_busy
);
  logic                  w_hit, w_vld, w_act, w_lwb;
  logic [DATA_WIDTH-1:0] w_sdata;
  // Scan oldest-to-youngest so the last match (stage 0, highest slot) wins
  always_comb begin
    w_hit   = 1'b0;
    w_vld   = 1'b1;
    w_sdata = '0;
    for (int s = NUM_STG - 1; s >= STG_EX; s--)
      for (int k = 0; k < ISSUE_W; k++)
        if (i_stg_wen[flat_idx(s, k, ISSUE_W)] &&
            i_stg_rd_addr[flat_idx(s, k, ISSUE_W)*RF_ADDR_WIDTH +: RF_ADDR_WIDTH] == i_addr) begin
          w_hit   = 1'b1;
          w_vld   = i_stg_data_vld[flat_idx(s, k, ISSUE_W)];
          w_sdata = i_stg_data[flat_idx(s, k, ISSUE_W)*DATA_WIDTH +: DATA_WIDTH];
        end
    w_act  = i_use && i_addr != '0;
    w_lwb  = i_lwb_valid && i_lwb_addr == i_addr;
    o_data = !w_act ? i_rf_data : w_hit ? w_sdata : w_lwb ? i_lwb_data : i_rf_data;
    o_nrdy = w_act && w_hit && !w_vld;
    o_busy = w_act && i_sb_busy[i_addr] && !(w_lwb && !w_hit);
  end
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: decode-stage forwarding, scoreboard, bundle split and stall counting
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int ISSUE_W       = 2,
  parameter int NUM_STG       = STG_WB + 1,
  parameter int DATA_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH     = 32
) (
  input logic             clk,
  input logic             rst_n,
  fwd_hazard_ctrl_if.slave bus
);
  localparam int AW = RF_ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  logic [ISSUE_W-1:0]   w_nrdy1, w_nrdy2, w_busy1, w_busy2, w_blk, w_mask;
  logic [AW-1:0]        w_rs1 [ISSUE_W];
  logic [AW-1:0]        w_rs2 [ISSUE_W];
  logic [AW-1:0]        w_rd  [ISSUE_W];
  logic [2**AW-1:0]     r_sb, w_set, w_clr;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_ok;
  for (genvar i = 0; i < ISSUE_W; i++) begin : g_slot
    assign w_rs1[i] = bus.dec_rs1_addr[i*AW +: AW];
    assign w_rs2[i] = bus.dec_rs2_addr[i*AW +: AW];
    assign w_rd[i]  = bus.dec_rd_addr[i*AW +: AW];
    fwd_src_sel #(.ISSUE_W(ISSUE_W), .NUM_STG(NUM_STG), .DATA_WIDTH(DW), .RF_ADDR_WIDTH(AW)) u_rs1 (
      .i_addr(w_rs1[i]), .i_use(bus.dec_rs1_use[i]), .i_rf_data(bus.rf_rs1_data[i*DW +: DW]),
      .i_stg_rd_addr(bus.stg_rd_addr), .i_stg_wen(bus.stg_wen), .i_stg_data_vld(bus.stg_data_vld),
      .i_stg_data(bus.stg_data), .i_lwb_valid(bus.lwb_valid), .i_lwb_addr(bus.lwb_addr),
      .i_lwb_data(bus.lwb_data), .i_sb_busy(r_sb), .o_data(bus.fwd_rs1_data[i*DW +: DW]),
      .o_nrdy(w_nrdy1[i]), .o_busy(w_busy1[i]));
    fwd_src_sel #(.ISSUE_W(ISSUE_W), .NUM_STG(NUM_STG), .DATA_WIDTH(DW), .RF_ADDR_WIDTH(AW)) u_rs2 (
      .i_addr(w_rs2[i]), .i_use(bus.dec_rs2_use[i]), .i_rf_data(bus.rf_rs2_data[i*DW +: DW]),
      .i_stg_rd_addr(bus.stg_rd_addr), .i_stg_wen(bus.stg_wen), .i_stg_data_vld(bus.stg_data_vld),
      .i_stg_data(bus.stg_data), .i_lwb_valid(bus.lwb_valid), .i_lwb_addr(bus.lwb_addr),
      .i_lwb_data(bus.lwb_data), .i_sb_busy(r_sb), .o_data(bus.fwd_rs2_data[i*DW +: DW]),
      .o_nrdy(w_nrdy2[i]), .o_busy(w_busy2[i]));
  end
  // Operand hazards, scoreboard WAW, then RAW/WAW against older valid slots of the bundle
  always_comb begin
    w_blk  = '0;
    w_mask = '0;
    w_ok   = 1'b1;
    w_set  = '0;
    w_clr  = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      w_blk[i] = w_nrdy1[i] | w_nrdy2[i] | w_busy1[i] | w_busy2[i] |
                 (bus.dec_rd_wen[i] && w_rd[i] != '0 && r_sb[w_rd[i]]);
      for (int j = 0; j < i; j++)
        w_blk[i] = w_blk[i] | (bus.dec_valid[j] && bus.dec_rd_wen[j] && w_rd[j] != '0 &&
                   ((bus.dec_rs1_use[i] && w_rs1[i] == w_rd[j]) ||
                    (bus.dec_rs2_use[i] && w_rs2[i] == w_rd[j]) ||
                    (bus.dec_rd_wen[i] && w_rd[i] == w_rd[j])));
      w_blk[i]  = w_blk[i] & bus.dec_valid[i];
      w_ok      = w_ok & ~w_blk[i];
      w_mask[i] = bus.dec_valid[i] & w_ok;
      if (bus.issue_fire && w_mask[i] && bus.dec_long[i] && bus.dec_rd_wen[i] && w_rd[i] != '0)
        w_set[w_rd[i]] = 1'b1;
    end
    if (bus.lwb_valid)
      w_clr[bus.lwb_addr] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sb  <= '0;
      r_cnt <= '0;
    end else begin
      r_sb  <= w_set | (r_sb & ~w_clr);
      r_cnt <= (bus.stall_req && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
    end
  assign bus.issue_mask = w_mask;
  assign bus.stall_req  = bus.dec_valid[0] & w_blk[0];
  assign bus.stall_cnt  = r_cnt;
  assign bus.sb_busy    = r_sb;
endmodule
